// File: rtl/arp_rx_if.sv
// Receive-side AXI-Stream beat bundle feeding the ARP request filter.
interface arp_rx_if;
    logic [31:0] rx_axis_tdata;
    logic        rx_axis_tvalid;
    logic        rx_axis_tlast;
    logic        rx_axis_tready;

    modport master (
        output rx_axis_tdata,
        output rx_axis_tvalid,
        output rx_axis_tlast,
        input  rx_axis_tready
    );

    modport slave (
        input  rx_axis_tdata,
        input  rx_axis_tvalid,
        input  rx_axis_tlast,
        output rx_axis_tready
    );
endinterface

// File: rtl/arp_rx.sv
// ARP request filter: parses received Ethernet frames and raises a held request for
// ARP requests aimed at LOCAL_MAC/broadcast and LOCAL_IP. Define ARP_RX_STATS_EN for counters.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | between frames, next valid beat is word 0
// S_PARSE | frame in progress, every check so far has passed
// S_DROP  | frame rejected, discard beats until tlast
// S_HOLD  | request accepted, rx_arp_req held for REQ_HOLD cycles
module arp_rx #(
    parameter logic [47:0] LOCAL_MAC = 48'h01_02_03_04_05_06,
    parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_01,
    parameter int          REQ_HOLD  = 8
) (
    input  logic        rx_mac_aclk,
    input  logic        rx_mac_resetn,
    arp_rx_if.slave     s_axis,
    output logic        rx_arp_req,
    output logic [47:0] rx_arp_smac,
    output logic [31:0] rx_arp_sip
`ifdef ARP_RX_STATS_EN
   ,output logic [15:0] arp_req_cnt,
    output logic [15:0] arp_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PARSE,
        S_DROP,
        S_HOLD
    } state_t;

    localparam logic [3:0] IDX_MAX   = 4'd11;
    localparam logic [3:0] HOLD_LAST = 4'(REQ_HOLD - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_hold_cnt;
    logic        r_tready;
    logic        r_dm_loc;
    logic        r_dm_bc;
    logic        r_hold_frm;
    logic [47:0] r_sh_smac;
    logic [31:0] r_sh_sip;
    logic        r_arp_req;
    logic [47:0] r_arp_smac;
    logic [31:0] r_arp_sip;

    logic [31:0] w_d;
    logic        w_beat;
    logic        w_last;
    logic        w_ok;
    logic        w_dm_loc;
    logic        w_dm_bc;
    logic        w_len_ok;
    logic        w_accept;
    logic        w_hold_done;
    logic        w_frm_open;

    assign s_axis.rx_axis_tready = r_tready;
    assign rx_arp_req  = r_arp_req;
    assign rx_arp_smac = r_arp_smac;
    assign rx_arp_sip  = r_arp_sip;

    assign w_d         = s_axis.rx_axis_tdata;
    assign w_beat      = s_axis.rx_axis_tvalid & r_tready;
    assign w_last      = w_beat & s_axis.rx_axis_tlast;
    assign w_dm_loc    = (w_d == LOCAL_MAC[47:16]);
    assign w_dm_bc     = (w_d == 32'hFFFF_FFFF);
    assign w_len_ok    = (r_idx >= 4'd10);
    assign w_hold_done = (r_hold_cnt == 4'd0);
    assign w_accept    = (r_state == S_PARSE) & w_last & w_ok & w_len_ok;
    // A frame still open when HOLD ends began inside HOLD and must be discarded.
    assign w_frm_open  = w_beat ? ~s_axis.rx_axis_tlast : r_hold_frm;

    // Destination MAC spans words 0 and 1; both halves must agree on local vs broadcast.
    always_comb begin
        w_ok = 1'b1;
        case (r_idx)
            4'd0:    w_ok = w_dm_loc | w_dm_bc;
            4'd1:    w_ok = (r_dm_loc & (w_d[31:16] == LOCAL_MAC[15:0])) |
                            (r_dm_bc  & (w_d[31:16] == 16'hFFFF));
            4'd3:    w_ok = (w_d == 32'h0806_0001);
            4'd4:    w_ok = (w_d == 32'h0800_0604);
            4'd5:    w_ok = (w_d[31:16] == 16'h0001);
            4'd9:    w_ok = (w_d[15:0] == LOCAL_IP[31:16]);
            4'd10:   w_ok = (w_d[31:16] == LOCAL_IP[15:0]);
            default: w_ok = 1'b1;
        endcase
    end

    always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
        if (!rx_mac_resetn) begin
            r_tready  <= 1'b0;
            r_idx     <= 4'd0;
            r_dm_loc  <= 1'b0;
            r_dm_bc   <= 1'b0;
            r_sh_smac <= 48'd0;
            r_sh_sip  <= 32'd0;
        end else begin
            r_tready <= 1'b1;
            if (w_beat) begin
                if (s_axis.rx_axis_tlast) begin
                    r_idx <= 4'd0;
                end else if (r_idx != IDX_MAX) begin
                    r_idx <= r_idx + 4'd1;
                end
                case (r_idx)
                    4'd0: begin
                        r_dm_loc <= w_dm_loc;
                        r_dm_bc  <= w_dm_bc;
                    end
                    4'd5:    r_sh_smac[47:32] <= w_d[15:0];
                    4'd6:    r_sh_smac[31:0]  <= w_d;
                    4'd7:    r_sh_sip         <= w_d;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
        if (!rx_mac_resetn) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 4'd0;
            r_hold_frm <= 1'b0;
            r_arp_req  <= 1'b0;
            r_arp_smac <= 48'd0;
            r_arp_sip  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_beat && !s_axis.rx_axis_tlast) begin
                        r_state <= w_ok ? S_PARSE : S_DROP;
                    end
                end
                S_PARSE: begin
                    if (w_accept) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= HOLD_LAST;
                        r_hold_frm <= 1'b0;
                        r_arp_req  <= 1'b1;
                        r_arp_smac <= r_sh_smac;
                        r_arp_sip  <= r_sh_sip;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                    end else if (w_beat && !w_ok) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (w_beat) begin
                        r_hold_frm <= ~s_axis.rx_axis_tlast;
                    end
                    if (w_hold_done) begin
                        r_arp_req <= 1'b0;
                        r_state   <= w_frm_open ? S_DROP : S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARP_RX_STATS_EN
    // Every frame end that is not an accept counts as one drop.
    logic w_drop;
    assign w_drop = w_last & ~w_accept;

    always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
        if (!rx_mac_resetn) begin
            arp_req_cnt  <= 16'd0;
            arp_drop_cnt <= 16'd0;
        end else begin
            if (w_accept && (arp_req_cnt != 16'hFFFF)) begin
                arp_req_cnt <= arp_req_cnt + 16'd1;
            end
            if (w_drop && (arp_drop_cnt != 16'hFFFF)) begin
                arp_drop_cnt <= arp_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: accept/reject frames, hold pulse timing, back-to-back and reset cases.
module tb_arp_rx;
    localparam int REQ_HOLD = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req;
    logic [47:0] smac;
    logic [31:0] sip;
`ifdef ARP_RX_STATS_EN
    logic [15:0] req_cnt;
    logic [15:0] drop_cnt;
`endif

    arp_rx_if axis_if ();

    arp_rx #(
        .REQ_HOLD (REQ_HOLD)
    ) dut (
        .rx_mac_aclk   (clk),
        .rx_mac_resetn (rst_n),
        .s_axis        (axis_if),
        .rx_arp_req    (req),
        .rx_arp_smac   (smac),
        .rx_arp_sip    (sip)
`ifdef ARP_RX_STATS_EN
       ,.arp_req_cnt   (req_cnt),
        .arp_drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Pulse observer: cycles with req high and number of rising edges.
    int   hi_cnt = 0;
    int   pulses = 0;
    int   hi0    = 0;
    int   p0     = 0;
    logic req_q  = 1'b0;
    always @(posedge clk) begin
        if (req === 1'b1) hi_cnt++;
        if (req === 1'b1 && req_q !== 1'b1) pulses++;
        req_q = req;
    end

    logic [31:0] fr [0:13];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input int exp_req, input int exp_drop);
`ifdef ARP_RX_STATS_EN
        chk({tag, "_req_cnt"},  64'(req_cnt),  64'(exp_req));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
`else
        if (exp_req < 0 || exp_drop < 0) $display("stats %s unused", tag);
`endif
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] oper,
                         input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
        fr[0]  = dmac[47:16];
        fr[1]  = {dmac[15:0], sha[47:32]};
        fr[2]  = sha[31:0];
        fr[3]  = {etype, 16'h0001};
        fr[4]  = 32'h0800_0604;
        fr[5]  = {oper, sha[47:32]};
        fr[6]  = sha[31:0];
        fr[7]  = spa;
        fr[8]  = 32'h0;
        fr[9]  = {16'h0, tpa[31:16]};
        fr[10] = {tpa[15:0], 16'h0};
        fr[11] = 32'h0;
        fr[12] = 32'h0;
        fr[13] = 32'h0;
    endtask

    task automatic send(input int n, input bit gaps, input bit idle_after);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    @(negedge clk);
                    axis_if.rx_axis_tvalid = 1'b0;
                    axis_if.rx_axis_tlast  = 1'b0;
                end
            end
            @(negedge clk);
            axis_if.rx_axis_tvalid = 1'b1;
            axis_if.rx_axis_tdata  = fr[i];
            axis_if.rx_axis_tlast  = (i == n - 1);
        end
        if (idle_after) begin
            @(negedge clk);
            axis_if.rx_axis_tvalid = 1'b0;
            axis_if.rx_axis_tlast  = 1'b0;
            axis_if.rx_axis_tdata  = 32'h0;
        end
    endtask

    task automatic obs_start();
        hi0 = hi_cnt;
        p0  = pulses;
    endtask

    task automatic obs_end(input string tag, input int exp_hi, input int exp_p);
        repeat (REQ_HOLD + 4) @(negedge clk);
        chk({tag, "_hi_cycles"}, 64'(hi_cnt - hi0), 64'(exp_hi));
        chk({tag, "_pulses"},    64'(pulses - p0),  64'(exp_p));
    endtask

    initial begin
        axis_if.rx_axis_tvalid = 1'b0;
        axis_if.rx_axis_tlast  = 1'b0;
        axis_if.rx_axis_tdata  = 32'h0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_tready", 64'(axis_if.rx_axis_tready), 64'd0);
        chk("rst_req",    64'(req),  64'd0);
        chk("rst_smac",   64'(smac), 64'd0);
        chk("rst_sip",    64'(sip),  64'd0);
        chk_stats("rst", 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rel_tready_0", 64'(axis_if.rx_axis_tready), 64'd0);
        @(negedge clk);
        chk("rel_tready_1", 64'(axis_if.rx_axis_tready), 64'd1);

        // Broadcast request to our IP
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0164, 32'hC0A8_0101);
        obs_start();
        send(11, 1'b0, 1'b1);
        chk("bc_latency", 64'(req), 64'd1);
        chk("bc_smac", 64'(smac), 64'h0011_2233_4455);
        chk("bc_sip",  64'(sip),  64'hC0A8_0164);
        obs_end("bc", REQ_HOLD, 1);
        chk_stats("bc", 1, 0);

        // Same frame, wrong target IP
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0164, 32'hC0A8_0102);
        obs_start();
        send(11, 1'b0, 1'b1);
        chk("tip_req", 64'(req), 64'd0);
        obs_end("tip", 0, 0);
        chk_stats("tip", 1, 1);

        // ARP reply to LOCAL_MAC, then IPv4 ethertype
        build(48'h0102_0304_0506, 16'h0806, 16'h0002, 48'hAABB_CCDD_EEFF, 32'hC0A8_0105, 32'hC0A8_0101);
        obs_start();
        send(11, 1'b0, 1'b1);
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 16'h0001, 48'hAABB_CCDD_EEFF, 32'hC0A8_0105, 32'hC0A8_0101);
        send(11, 1'b0, 1'b1);
        obs_end("reply_ipv4", 0, 0);
        chk("reply_ipv4_smac", 64'(smac), 64'h0011_2233_4455);
        chk_stats("reply_ipv4", 1, 3);

        // Unicast request to LOCAL_MAC
        build(48'h0102_0304_0506, 16'h0806, 16'h0001, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0110, 32'hC0A8_0101);
        obs_start();
        send(11, 1'b0, 1'b1);
        chk("uc_smac", 64'(smac), 64'h0A0B_0C0D_0E0F);
        chk("uc_sip",  64'(sip),  64'hC0A8_0110);
        obs_end("uc", REQ_HOLD, 1);
        chk_stats("uc", 2, 3);

        // Destination MAC halves mixing local and broadcast
        build(48'h0102_0304_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_0099, 32'hC0A8_0199, 32'hC0A8_0101);
        obs_start();
        send(11, 1'b0, 1'b1);
        build(48'hFFFF_FFFF_0506, 16'h0806, 16'h0001, 48'h0200_0000_0099, 32'hC0A8_0199, 32'hC0A8_0101);
        send(11, 1'b0, 1'b1);
        obs_end("mixmac", 0, 0);
        chk("mixmac_smac", 64'(smac), 64'h0A0B_0C0D_0E0F);
        chk_stats("mixmac", 2, 5);

        // Truncated at index 8 and at index 9, then exact-length and over-length frames
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_0001, 32'hC0A8_010A, 32'hC0A8_0101);
        obs_start();
        send(9, 1'b0, 1'b1);
        send(10, 1'b0, 1'b1);
        obs_end("short", 0, 0);
        chk_stats("short", 2, 7);
        obs_start();
        send(11, 1'b0, 1'b1);
        chk("after_short_smac", 64'(smac), 64'h0200_0000_0001);
        chk("after_short_sip",  64'(sip),  64'hC0A8_010A);
        obs_end("after_short", REQ_HOLD, 1);
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_0002, 32'hC0A8_010B, 32'hC0A8_0101);
        obs_start();
        send(14, 1'b0, 1'b1);
        chk("long_sip", 64'(sip), 64'hC0A8_010B);
        obs_end("long", REQ_HOLD, 1);
        chk_stats("long", 4, 7);

        // Two valid requests back-to-back: second overlaps HOLD and is discarded
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_00AA, 32'hC0A8_01AA, 32'hC0A8_0101);
        obs_start();
        send(11, 1'b0, 1'b0);
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_00BB, 32'hC0A8_01BB, 32'hC0A8_0101);
        send(11, 1'b0, 1'b1);
        obs_end("b2b", REQ_HOLD, 1);
        chk("b2b_smac", 64'(smac), 64'h0200_0000_00AA);
        chk("b2b_sip",  64'(sip),  64'hC0A8_01AA);
        chk_stats("b2b", 5, 8);

        // Rejected frame immediately followed by a valid one
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_0077, 32'hC0A8_0177, 32'hC0A8_0177);
        obs_start();
        send(11, 1'b0, 1'b0);
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_00CC, 32'hC0A8_01CC, 32'hC0A8_0101);
        send(11, 1'b0, 1'b1);
        chk("rej_b2b_latency", 64'(req), 64'd1);
        obs_end("rej_b2b", REQ_HOLD, 1);
        chk("rej_b2b_smac", 64'(smac), 64'h0200_0000_00CC);
        chk_stats("rej_b2b", 6, 9);

        // Reset at index 6 of a valid request, then a request with tvalid gaps
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_00DD, 32'hC0A8_01DD, 32'hC0A8_0101);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            axis_if.rx_axis_tvalid = 1'b1;
            axis_if.rx_axis_tdata  = fr[i];
            axis_if.rx_axis_tlast  = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req",    64'(req),  64'd0);
        chk("midrst_smac",   64'(smac), 64'd0);
        chk("midrst_sip",    64'(sip),  64'd0);
        chk("midrst_tready", 64'(axis_if.rx_axis_tready), 64'd0);
        chk_stats("midrst", 0, 0);
        @(negedge clk);
        axis_if.rx_axis_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_rel_tready_0", 64'(axis_if.rx_axis_tready), 64'd0);
        @(negedge clk);
        chk("midrst_rel_tready_1", 64'(axis_if.rx_axis_tready), 64'd1);
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0001, 48'h0200_0000_00EE, 32'hC0A8_01EE, 32'hC0A8_0101);
        obs_start();
        send(11, 1'b1, 1'b1);
        chk("gap_latency", 64'(req), 64'd1);
        chk("gap_smac", 64'(smac), 64'h0200_0000_00EE);
        chk("gap_sip",  64'(sip),  64'hC0A8_01EE);
        obs_end("gap", REQ_HOLD, 1);
        chk_stats("gap", 1, 0);

        // Reset in the middle of HOLD
        build(48'h0102_0304_0506, 16'h0806, 16'h0001, 48'h0200_0000_00FF, 32'hC0A8_01FF, 32'hC0A8_0101);
        send(11, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("holdrst_req_pre", 64'(req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("holdrst_req",  64'(req),  64'd0);
        chk("holdrst_smac", 64'(smac), 64'd0);
        chk("holdrst_sip",  64'(sip),  64'd0);
        chk_stats("holdrst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
